ad_capture: RTL

Serial front end for the two dual-channel 12-bit A/D converters on the 2.5 V bank. It generates the shared `ad_cs` frame strobe and deserialises the four `ad_sdata` lines into 12-bit samples. It also produces a power-of-two boxcar average per channel and flags malformed frames. It sits between the `ad_cs`/`ad_sdata_a`/`ad_sdata_b` pads and the consumers of `ad_a0`/`ad_a1`/`ad_b0`/`ad_b1`: the blaster control loop and both video overlays. Converter serial clock is the inverted system clock, so data is sampled on `clk` rising edges.

---
 rtl/ad_capture_if.sv | 32 +++
 rtl/ad_capture.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/ad_capture_if.sv
// Pad and consumer-side signal bundle for the dual-converter A/D front end.
// The capture block takes the master view; pads/consumers take the slave view.
interface ad_capture_if;
    logic        en;
    logic        err_clr;
    logic        ad_cs;
    logic [1:0]  ad_sdata_a;
    logic [1:0]  ad_sdata_b;
    logic [11:0] ad_a0;
    logic [11:0] ad_a1;
    logic [11:0] ad_b0;
    logic [11:0] ad_b1;
    logic        sample_valid;
    logic [11:0] avg_a0;
    logic [11:0] avg_a1;
    logic [11:0] avg_b0;
    logic [11:0] avg_b1;
    logic        avg_valid;
    logic        frame_err;

    modport master (
        input  en, err_clr, ad_sdata_a, ad_sdata_b,
        output ad_cs, ad_a0, ad_a1, ad_b0, ad_b1, sample_valid,
               avg_a0, avg_a1, avg_b0, avg_b1, avg_valid, frame_err
    );

    modport slave (
        output en, err_clr, ad_sdata_a, ad_sdata_b,
        input  ad_cs, ad_a0, ad_a1, ad_b0, ad_b1, sample_valid,
               avg_a0, avg_a1, avg_b0, avg_b1, avg_valid, frame_err
    );
endinterface

// File: rtl/ad_capture.sv
// Serial front end for two dual-channel 12-bit A/D converters: frame strobe
// generation, deserialisation, per-channel boxcar averaging and leading-zero
// frame checking. Channel order internally: 0=a0, 1=a1, 2=b0, 3=b1.
module ad_capture #(
    parameter int FRAME_LEN = 16,
    parameter int AVG_LOG2  = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    ad_capture_if.master bus
);
    localparam int CW   = $clog2(FRAME_LEN);
    localparam int AW   = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int ACCW = 12 + AVG_LOG2;
    localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_LEN - 1);
    localparam logic [AW-1:0] BLK_LAST = AW'((1 << AVG_LOG2) - 1);

    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nxt;
    logic            cs_q;
    logic [3:0]      line;
    logic            in_lz;
    logic            in_data;
    logic            load;
    logic            lz_seen;
    logic            sample_valid_q;
    logic            avg_valid_q;
    logic            frame_err_q;
    logic [AW-1:0]   blk_cnt;
    logic            blk_end;
    logic [11:0]     sr       [4];
    logic [11:0]     samp     [4];
    logic [11:0]     avg      [4];
    logic [ACCW-1:0] acc      [4];
    logic [ACCW-1:0] acc_sum  [4];
    logic [11:0]     avg_next [4];

    assign line    = {bus.ad_sdata_b, bus.ad_sdata_a};
    assign load    = (cnt == CNT_LAST);
    assign in_lz   = (cnt == CW'(1)) || (cnt == CW'(2));
    assign in_data = (cnt >= CW'(3)) && (cnt <= CW'(14));
    assign blk_end = (blk_cnt == BLK_LAST);

    // Next frame count: idle at 0 until enabled, otherwise run to wrap.
    always_comb begin
        cnt_nxt = cnt;
        if (cnt == '0) begin
            if (bus.en) begin
                cnt_nxt = CW'(1);
            end
        end else if (cnt == CNT_LAST) begin
            cnt_nxt = '0;
        end else begin
            cnt_nxt = cnt + CW'(1);
        end
    end

    // Chip select is registered from the next count so it is high exactly while cnt==0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt  <= '0;
            cs_q <= 1'b1;
        end else begin
            cnt  <= cnt_nxt;
            cs_q <= (cnt_nxt == '0);
        end
    end

    // Shift in D11..D0 and remember any nonzero leading-zero bit for this frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned ch = 0; ch < 4; ch++) begin
                sr[ch] <= '0;
            end
            lz_seen <= 1'b0;
        end else begin
            if (in_data) begin
                for (int unsigned ch = 0; ch < 4; ch++) begin
                    sr[ch] <= {sr[ch][10:0], line[ch]};
                end
            end
            if (load) begin
                lz_seen <= 1'b0;
            end else if (in_lz && (|line)) begin
                lz_seen <= 1'b1;
            end
        end
    end

    // Running sum including the sample being loaded, and its scaled average.
    always_comb begin
        for (int unsigned ch = 0; ch < 4; ch++) begin
            acc_sum[ch]  = acc[ch] + ACCW'(sr[ch]);
            avg_next[ch] = 12'(acc_sum[ch] >> AVG_LOG2);
        end
    end

    // Load samples at frame end; close an averaging block every 2^AVG_LOG2 loads.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned ch = 0; ch < 4; ch++) begin
                samp[ch] <= '0;
                avg[ch]  <= '0;
                acc[ch]  <= '0;
            end
            blk_cnt        <= '0;
            sample_valid_q <= 1'b0;
            avg_valid_q    <= 1'b0;
        end else begin
            sample_valid_q <= load;
            avg_valid_q    <= load && blk_end;
            if (load) begin
                for (int unsigned ch = 0; ch < 4; ch++) begin
                    samp[ch] <= sr[ch];
                    if (blk_end) begin
                        avg[ch] <= avg_next[ch];
                        acc[ch] <= '0;
                    end else begin
                        acc[ch] <= acc_sum[ch];
                    end
                end
                blk_cnt <= blk_end ? '0 : blk_cnt + AW'(1);
            end
        end
    end

    // Sticky frame error; a set at the load edge overrides a simultaneous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_err_q <= 1'b0;
        end else if (load && lz_seen) begin
            frame_err_q <= 1'b1;
        end else if (bus.err_clr) begin
            frame_err_q <= 1'b0;
        end
    end

    assign bus.ad_cs        = cs_q;
    assign bus.ad_a0        = samp[0];
    assign bus.ad_a1        = samp[1];
    assign bus.ad_b0        = samp[2];
    assign bus.ad_b1        = samp[3];
    assign bus.sample_valid = sample_valid_q;
    assign bus.avg_a0       = avg[0];
    assign bus.avg_a1       = avg[1];
    assign bus.avg_b0       = avg[2];
    assign bus.avg_b1       = avg[3];
    assign bus.avg_valid    = avg_valid_q;
    assign bus.frame_err    = frame_err_q;
endmodule
